// File: rtl/rv_pkg.sv
// rv_pkg
//   Shared RV32I definitions for the control unit and the instruction
//   encoder: base opcodes, the instruction-class enum carried on in_op,
//   ALU control codes, funct3/funct7 values, the canonical NOP and a
//   signed-range helper for immediate legality checks.
package rv_pkg;

  // Base opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Instruction class as presented on in_op
  typedef enum logic [2:0] {
    OP_R      = 3'd0,
    OP_I      = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JAL    = 3'd5,
    OP_JALR   = 3'd6,
    OP_LUI    = 3'd7
  } op_e;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  // funct3 / funct7 values for OP / OP-IMM and JALR
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when v is representable as a two's-complement number of 'bits' bits:
  // every bit from bits-1 upward must equal the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] top;
    top = $signed(v) >>> (bits - 1);
    return (top == '0) || (top == '1);
  endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// rv_instr_pack
//   Combinational packer: one field-level descriptor in, one RV32I word out.
//   Any illegal field combination yields NOP with o_illegal set.
//   Ports:
//     i_op      instruction class (rv_pkg::op_e encoding)
//     i_alu     ALU control code (R and I classes only)
//     i_funct3  width/condition field (LOAD, STORE, BRANCH, JALR)
//     i_rd/i_rs1/i_rs2  register indices
//     i_imm     signed immediate (byte offset for B/J, upper value for LUI)
//     o_word    encoded instruction
//     o_illegal descriptor could not be encoded
module rv_instr_pack
  import rv_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [3:0]  i_alu,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic        w_alu_ok;
  logic        w_is_shift;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_word;
  logic        w_illegal;

  always_comb begin
    w_alu_ok   = 1'b1;
    w_is_shift = 1'b0;
    w_f3       = F3_ADD_SUB;
    w_f7       = F7_BASE;
    case (i_alu)
      ALU_ADD: w_f3 = F3_ADD_SUB;
      ALU_SUB: begin w_f3 = F3_ADD_SUB; w_f7 = F7_ALT; end
      ALU_SLL: begin w_f3 = F3_SLL; w_is_shift = 1'b1; end
      ALU_AND: w_f3 = F3_AND;
      ALU_OR:  w_f3 = F3_OR;
      ALU_XOR: w_f3 = F3_XOR;
      ALU_SLT: w_f3 = F3_SLT;
      ALU_SRL: begin w_f3 = F3_SRL_SRA; w_is_shift = 1'b1; end
      ALU_SRA: begin w_f3 = F3_SRL_SRA; w_f7 = F7_ALT; w_is_shift = 1'b1; end
      default: w_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_word    = NOP;
    w_illegal = 1'b0;
    case (op_e'(i_op))
      OP_R: begin
        if (!w_alu_ok) w_illegal = 1'b1;
        else w_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OPC_R};
      end
      OP_I: begin
        if (!w_alu_ok || (i_alu == ALU_SUB)) begin
          w_illegal = 1'b1;
        end else if (w_is_shift) begin
          // Shift-immediates carry funct7 above a 5-bit shamt
          if (i_imm[31:5] != '0) w_illegal = 1'b1;
          else w_word = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, OPC_I};
        end else begin
          if (!fits_signed(i_imm, 12)) w_illegal = 1'b1;
          else w_word = {i_imm[11:0], i_rs1, w_f3, i_rd, OPC_I};
        end
      end
      OP_LOAD: begin
        if (!(i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
            !fits_signed(i_imm, 12))
          w_illegal = 1'b1;
        else
          w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
      end
      OP_STORE: begin
        if (!(i_funct3 inside {3'b000, 3'b001, 3'b010}) || !fits_signed(i_imm, 12))
          w_illegal = 1'b1;
        else
          w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
      end
      OP_BRANCH: begin
        if ((i_funct3 inside {3'b010, 3'b011}) || i_imm[0] || !fits_signed(i_imm, 13))
          w_illegal = 1'b1;
        else
          w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], OPC_BRANCH};
      end
      OP_JAL: begin
        if (i_imm[0] || !fits_signed(i_imm, 21))
          w_illegal = 1'b1;
        else
          w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
      end
      OP_JALR: begin
        if ((i_funct3 != F3_JALR) || !fits_signed(i_imm, 12))
          w_illegal = 1'b1;
        else
          w_word = {i_imm[11:0], i_rs1, F3_JALR, i_rd, OPC_JALR};
      end
      OP_LUI: begin
        if (i_imm[11:0] != '0) w_illegal = 1'b1;
        else w_word = {i_imm[31:12], i_rd, OPC_LUI};
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) w_word = NOP;
  end

  assign o_word    = w_word;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
//   Counted load session: accepts descriptors over a valid/ready stream,
//   encodes each one and writes it to consecutive instruction-memory word
//   addresses starting at BASE_ADDR (wrapping modulo 2^IMEM_AW).
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     start, count       begin a session of 'count' words (IDLE/DONE only)
//     in_valid/in_ready  descriptor handshake
//     in_op .. in_imm    descriptor fields
//     imem_we/addr/wdata registered instruction-memory write port
//     busy, done         session in progress / finished
//     err                sticky: some descriptor in this session was illegal
module rv_instr_encoder
  import rv_pkg::*;
#(
  parameter int unsigned         IMEM_AW   = 8,
  parameter logic [IMEM_AW-1:0]  BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IMEM_AW:0]   count,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [3:0]         in_alu,
  input  logic [2:0]         in_funct3,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [31:0]        in_imm,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e             r_state;
  logic [IMEM_AW:0]   r_remaining;
  logic [IMEM_AW-1:0] r_ptr;
  logic               r_we;
  logic [IMEM_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [31:0]        w_word;
  logic               w_illegal;
  logic               w_ready;
  logic               w_xfer;

  rv_instr_pack u_pack (
    .i_op      (in_op),
    .i_alu     (in_alu),
    .i_funct3  (in_funct3),
    .i_rd      (in_rd),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_ready = (r_state == S_LOAD) && (r_remaining != '0);
  assign w_xfer  = in_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_ptr       <= BASE_ADDR;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_remaining <= count;
            r_ptr       <= BASE_ADDR;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_we        <= 1'b1;
            r_addr      <= r_ptr;
            r_wdata     <= w_word;
            r_ptr       <= r_ptr + IMEM_AW'(1);
            r_remaining <= r_remaining - (IMEM_AW+1)'(1);
            if (w_illegal) r_err <= 1'b1;
          end else if (r_remaining == '0) begin
            // The last word was presented in the cycle just ending, so
            // done rises immediately after the final write strobe.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: two instances (BASE_ADDR 0x10 and 0xFF) share
// all inputs; expected writes are queued at transfer time and checked by a
// monitor whenever a write strobe appears.
module tb_rv_instr_encoder;

  localparam logic [7:0] BASE_A = 8'h10;
  localparam logic [7:0] BASE_B = 8'hFF;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  count;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [3:0]  in_alu;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        a_ready, a_we, a_busy, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;

  rv_instr_encoder #(.IMEM_AW(8), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_op(in_op), .in_alu(in_alu), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  rv_instr_encoder #(.IMEM_AW(8), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_op(in_op), .in_alu(in_alu), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          fixed;
    logic [31:0] fixed_word;
    bit          fixed_ill;
  } desc_t;

  typedef struct {
    logic [31:0] word;
    int unsigned idx;
  } exp_t;

  desc_t dq[$];
  exp_t  qa[$], qb[$];

  int total = 0;
  int bad   = 0;
  bit exp_last_we = 0;
  bit pa_we = 0, pa_done = 0, pb_we = 0, pb_done = 0;

  logic [3:0] alu_codes [9] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                4'b0100, 4'b0101, 4'b0110, 4'b1101};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder: ranges checked as integers, fields placed by shifts.
  function automatic void ref_encode(input desc_t d, output logic [31:0] w, output bit ill);
    int          s;
    logic [31:0] u;
    logic [31:0] f3, f7;
    bit          aok, shift;
    s = $signed(d.imm);
    u = d.imm;
    ill = 0; w = 32'h0; aok = 1; shift = 0; f7 = 0; f3 = 0;
    case (d.alu)
      4'd0:  f3 = 0;
      4'd8:  begin f3 = 0; f7 = 32'h20; end
      4'd1:  begin f3 = 1; shift = 1; end
      4'd2:  f3 = 7;
      4'd3:  f3 = 6;
      4'd4:  f3 = 4;
      4'd5:  f3 = 2;
      4'd6:  begin f3 = 5; shift = 1; end
      4'd13: begin f3 = 5; f7 = 32'h20; shift = 1; end
      default: aok = 0;
    endcase
    case (d.op)
      3'd0: if (!aok) ill = 1;
            else w = (f7 << 25) | (32'(d.rs2) << 20) | (32'(d.rs1) << 15) |
                     (f3 << 12) | (32'(d.rd) << 7) | 32'h33;
      3'd1: if (!aok || d.alu == 4'd8) ill = 1;
            else if (shift) begin
              if (s < 0 || s > 31) ill = 1;
              else w = (f7 << 25) | (u << 20) | (32'(d.rs1) << 15) |
                       (f3 << 12) | (32'(d.rd) << 7) | 32'h13;
            end else begin
              if (s < -2048 || s > 2047) ill = 1;
              else w = ((u & 32'hFFF) << 20) | (32'(d.rs1) << 15) |
                       (f3 << 12) | (32'(d.rd) << 7) | 32'h13;
            end
      3'd2: if (!(d.f3 == 0 || d.f3 == 1 || d.f3 == 2 || d.f3 == 4 || d.f3 == 5) ||
                s < -2048 || s > 2047) ill = 1;
            else w = ((u & 32'hFFF) << 20) | (32'(d.rs1) << 15) |
                     (32'(d.f3) << 12) | (32'(d.rd) << 7) | 32'h03;
      3'd3: if (d.f3 > 2 || s < -2048 || s > 2047) ill = 1;
            else w = (((u >> 5) & 32'h7F) << 25) | (32'(d.rs2) << 20) |
                     (32'(d.rs1) << 15) | (32'(d.f3) << 12) |
                     ((u & 32'h1F) << 7) | 32'h23;
      3'd4: if (d.f3 == 2 || d.f3 == 3 || (s % 2) != 0 || s < -4096 || s > 4095) ill = 1;
            else w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                     (32'(d.rs2) << 20) | (32'(d.rs1) << 15) | (32'(d.f3) << 12) |
                     (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      3'd5: if ((s % 2) != 0 || s < -(1 << 20) || s > (1 << 20) - 1) ill = 1;
            else w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                     (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                     (32'(d.rd) << 7) | 32'h6F;
      3'd6: if (d.f3 != 0 || s < -2048 || s > 2047) ill = 1;
            else w = ((u & 32'hFFF) << 20) | (32'(d.rs1) << 15) |
                     (32'(d.rd) << 7) | 32'h67;
      default: if ((u & 32'hFFF) != 0) ill = 1;
               else w = (u & 32'hFFFFF000) | (32'(d.rd) << 7) | 32'h37;
    endcase
    if (ill) w = 32'h13;
  endfunction

  function automatic desc_t mk(input logic [2:0] op, input logic [3:0] alu,
                               input logic [2:0] f3, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [31:0] fw,
                               input bit fi);
    desc_t d;
    d.op = op; d.alu = alu; d.f3 = f3; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.imm = imm; d.fixed = 1; d.fixed_word = fw; d.fixed_ill = fi;
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.op  = 3'($urandom_range(0, 7));
    d.alu = ($urandom_range(0, 7) == 0) ? 4'($urandom) : alu_codes[$urandom_range(0, 8)];
    d.f3  = 3'($urandom);
    d.rd  = 5'($urandom); d.rs1 = 5'($urandom); d.rs2 = 5'($urandom);
    case ($urandom_range(0, 6))
      0: d.imm = 32'($urandom_range(0, 40));
      1: d.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
      2: case ($urandom_range(0, 7))
           0: d.imm = 32'd2047;       1: d.imm = 32'd2048;
           2: d.imm = -32'sd2048;     3: d.imm = -32'sd2049;
           4: d.imm = 32'd4094;       5: d.imm = -32'sd4096;
           6: d.imm = 32'h000F_FFFE;  default: d.imm = 32'hFFF0_0000;
         endcase
      3: d.imm = $urandom;
      4: d.imm = $urandom & 32'hFFFF_F000;
      5: d.imm = 32'($signed($urandom_range(0, 32'h1F_FFFF)) - 32'sh10_0000);
      default: d.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
    d.fixed = 0; d.fixed_word = 0; d.fixed_ill = 0;
    return d;
  endfunction

  // Monitor: pops one expectation per write strobe, checks done timing.
  always @(negedge clk) begin
    exp_t e;
    if (a_we) begin
      if (qa.size() == 0) chk("a_unexpected_we", 32'(a_we), 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_addr", 32'(a_addr), 32'(8'(BASE_A + e.idx)));
        chk("a_wdata", a_wdata, e.word);
      end
    end
    if (b_we) begin
      if (qb.size() == 0) chk("b_unexpected_we", 32'(b_we), 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_addr", 32'(b_addr), 32'(8'(BASE_B + e.idx)));
        chk("b_wdata", b_wdata, e.word);
      end
    end
    if (a_done && !pa_done) chk("a_done_after_last_we", 32'(pa_we), 32'(exp_last_we));
    if (b_done && !pb_done) chk("b_done_after_last_we", 32'(pb_we), 32'(exp_last_we));
    pa_we = a_we; pa_done = a_done; pb_we = b_we; pb_done = b_done;
  end

  task automatic check_reset_values();
    chk("rst_a_ready", 32'(a_ready), 0); chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_a_we", 32'(a_we), 0);       chk("rst_b_we", 32'(b_we), 0);
    chk("rst_a_addr", 32'(a_addr), 32'(BASE_A));
    chk("rst_b_addr", 32'(b_addr), 32'(BASE_B));
    chk("rst_a_wdata", a_wdata, 0);      chk("rst_b_wdata", b_wdata, 0);
    chk("rst_a_busy", 32'(a_busy), 0);   chk("rst_b_busy", 32'(b_busy), 0);
    chk("rst_a_done", 32'(a_done), 0);   chk("rst_b_done", 32'(b_done), 0);
    chk("rst_a_err", 32'(a_err), 0);     chk("rst_b_err", 32'(b_err), 0);
  endtask

  task automatic drive(input desc_t d);
    in_op = d.op; in_alu = d.alu; in_funct3 = d.f3;
    in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2; in_imm = d.imm;
  endtask

  task automatic push_exp(input desc_t d, input int unsigned idx, inout bit eerr);
    logic [31:0] w;
    bit          ill;
    exp_t        e;
    ref_encode(d, w, ill);
    if (d.fixed) begin w = d.fixed_word; ill = d.fixed_ill; end
    e.word = w; e.idx = idx;
    qa.push_back(e); qb.push_back(e);
    eerr |= ill;
  endtask

  task automatic run_session(input int unsigned n, input bit mid_start);
    int unsigned xfers = 0, cyc = 0, k = 0;
    int unsigned bound = 4 * n + 50;
    bit          eerr = 0, have = 0;
    desc_t       d;
    exp_last_we = (n > 0);
    @(negedge clk);
    start = 1'b1; count = 9'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(a_busy), 1);
    chk("done_cleared_by_start", 32'(a_done), 0);
    while (xfers < n && cyc < bound) begin
      // A start pulse while loading must be ignored
      start = mid_start && (cyc == 2);
      if (start) count = 9'd5;
      if (!have) begin
        d = (dq.size() > 0) ? dq.pop_front() : rand_desc();
        have = 1;
      end
      drive(d);
      in_valid = ($urandom_range(0, 3) != 0);
      chk("a_in_ready_loading", 32'(a_ready), 1);
      chk("b_in_ready_loading", 32'(b_ready), 1);
      if (in_valid && a_ready) begin
        push_exp(d, xfers, eerr);
        xfers++;
        have = 0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    if (cyc >= bound) chk("session_transfer_timeout", xfers, n);
    while (!a_done && k < 10) begin @(negedge clk); k++; end
    chk("a_done", 32'(a_done), 1);   chk("b_done", 32'(b_done), 1);
    chk("a_err", 32'(a_err), 32'(eerr)); chk("b_err", 32'(b_err), 32'(eerr));
    chk("ready_in_done", 32'(a_ready), 0);
    chk("busy_in_done", 32'(a_busy), 0);
    @(negedge clk);
    chk("err_held_in_done", 32'(a_err), 32'(eerr));
    chk("queue_drained", 32'(qa.size() + qb.size()), 0);
  endtask

  task automatic run_reset_mid();
    desc_t d;
    bit    eerr = 0;
    @(negedge clk);
    start = 1'b1; count = 9'd3;
    @(negedge clk);
    start = 1'b0;
    d = rand_desc();
    drive(d);
    in_valid = 1'b1;
    chk("rst_sess_ready", 32'(a_ready), 1);
    push_exp(d, 0, eerr);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_ready_after_rst", 32'(a_ready), 0);
    end
    in_valid = 1'b0;
    chk("no_pending_after_rst", 32'(qa.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0;
    in_op = '0; in_alu = '0; in_funct3 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    dq.push_back(mk(3'd0, 4'b1000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 0));
    dq.push_back(mk(3'd1, 4'b0000, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00093, 0));
    dq.push_back(mk(3'd3, 4'b0000, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 0));
    run_session(3, 1);

    dq.push_back(mk(3'd5, 4'b0000, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDFF06F, 0));
    dq.push_back(mk(3'd5, 4'b0000, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h00000013, 1));
    run_session(2, 0);

    run_session(0, 0);
    run_reset_mid();

    repeat (12) run_session($urandom_range(1, 10), 0);
    run_session(256, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
